fifo_word_assembler: RTL and testbench

FIFO_WORD_ASSEMBLER -- requirements
Module: fifo_word_assembler

---
 rtl/fifo_word_assembler.sv | 95 +++++++++
 tb/tb_fifo_word_assembler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_assembler.sv
// fifo_word_assembler
// Pops WIDTH-bit entries from an upstream FIFO with a registered output and
// packs BYTES of them, first entry in the LSBs, into one output word. A
// finished word is held until the downstream side takes it.
module fifo_word_assembler #(
    parameter int WIDTH = 8,
    parameter int BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_read,
    input  logic [WIDTH-1:0]       fifo_data,
    input  logic                   flush,
    output logic [BYTES*WIDTH-1:0] word,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [3:0]             fill_level
);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [3:0] BYTES_C = 4'(BYTES);
    localparam logic [3:0] LAST_C  = 4'(BYTES - 1);

    logic [0:0]             state;
    logic [3:0]             issued;
    logic [3:0]             captured;
    logic                   vld_p1;
    logic [BYTES*WIDTH-1:0] word_p1;
    logic                   capture;
    logic                   accept;

    // Pop while collecting, data available, not flushing, and the word still
    // needs entries; reset low blocks pops outright.
    assign fifo_read = rst && (state == ST_FILL) && !fifo_empty && !flush
                       && (issued < BYTES_C);

    // vld_p1 marks that fifo_data carries the entry popped on the last edge.
    assign capture = vld_p1 && !flush;
    assign accept  = (state == ST_HOLD) && word_ready;

    assign word       = word_p1;
    assign word_valid = (state == ST_HOLD);
    assign fill_level = captured;

    // Control: pop/capture counters, pop-in-flight flag and FILL/HOLD state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_FILL;
            issued   <= 4'd0;
            captured <= 4'd0;
            vld_p1   <= 1'b0;
        end else if (flush) begin
            // An in-flight pop is dropped along with the partial word.
            state    <= ST_FILL;
            issued   <= 4'd0;
            captured <= 4'd0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= fifo_read;
            if (accept) begin
                // fifo_read is low in HOLD, so no pop is lost here.
                state    <= ST_FILL;
                issued   <= 4'd0;
                captured <= 4'd0;
            end else begin
                if (fifo_read) begin
                    issued <= issued + 4'd1;
                end
                if (capture) begin
                    captured <= captured + 4'd1;
                    if (captured == LAST_C) begin
                        state <= ST_HOLD;
                    end
                end
            end
        end
    end

    // Stage p0 -> p1: store the popped entry into its slot of the word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_p1 <= '0;
        end else if (capture) begin
            for (int i = 0; i < BYTES; i++) begin
                if (captured == 4'(i)) begin
                    word_p1[i*WIDTH +: WIDTH] <= fifo_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_assembler.sv
// tb_fifo_word_assembler
// Directed scenarios followed by randomized push/ready traffic. An 8-deep
// FIFO with registered output feeds the assembler; a queue of pushed
// entries predicts every word the assembler must deliver.
module tb_fifo_word_assembler;

    localparam int WIDTH = 8;
    localparam int BYTES = 4;

    logic                   clk;
    logic                   rst;
    logic                   fifo_empty;
    logic                   fifo_read;
    logic [WIDTH-1:0]       fifo_data;
    logic                   flush;
    logic [BYTES*WIDTH-1:0] word;
    logic                   word_valid;
    logic                   word_ready;
    logic [3:0]             fill_level;

    logic                   push_en;
    logic [WIDTH-1:0]       push_val;
    logic [WIDTH-1:0]       fifo_q[$];
    logic [WIDTH-1:0]       sb[$];

    int checks = 0;
    int errors = 0;

    fifo_word_assembler #(.WIDTH(WIDTH), .BYTES(BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO: registered data output and registered empty flag.
    initial begin
        fifo_empty = 1'b1;
        fifo_data  = '0;
    end
    always @(posedge clk) begin
        if (fifo_read && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        if (push_en && fifo_q.size() < 8) fifo_q.push_back(push_val);
        fifo_empty <= (fifo_q.size() == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic step1();
        @(negedge clk);
        #1;
    endtask

    task automatic push1(input logic [WIDTH-1:0] v);
        push_en  = 1'b1;
        push_val = v;
        step1();
        push_en  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (word_valid !== 1'b1 && n < 40) begin
            step1();
            n++;
        end
        chk({tag, "_valid"}, 64'(word_valid), 64'd1);
    endtask

    initial begin
        logic [BYTES*WIDTH-1:0] exp_word;
        rst        = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b1;
        push_en    = 1'b0;
        push_val   = '0;
        step1();
        step1();

        // Basic word: FIFO loaded while reset is held.
        push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
        step1();
        chk("rst_fifo_read", 64'(fifo_read), 64'd0);
        chk("rst_word_valid", 64'(word_valid), 64'd0);
        chk("rst_fill_level", 64'(fill_level), 64'd0);
        chk("rst_word", 64'(word), 64'd0);
        rst = 1'b1;
        #1;
        chk("basic_read_c0", 64'(fifo_read), 64'd1);
        step1(); chk("basic_read_c1", 64'(fifo_read), 64'd1);
        step1(); chk("basic_read_c2", 64'(fifo_read), 64'd1);
        step1(); chk("basic_read_c3", 64'(fifo_read), 64'd1);
        step1();
        chk("basic_read_c4", 64'(fifo_read), 64'd0);
        chk("basic_valid_c4", 64'(word_valid), 64'd0);
        step1();
        chk("basic_valid_c5", 64'(word_valid), 64'd1);
        chk("basic_word", 64'(word), 64'h44332211);
        chk("basic_fill_c5", 64'(fill_level), 64'd4);
        step1();
        chk("basic_valid_c6", 64'(word_valid), 64'd0);
        chk("basic_fill_c6", 64'(fill_level), 64'd0);

        // Backpressure: first word held while more entries wait in the FIFO.
        word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push1(8'(i));
        wait_valid("bp1");
        for (int i = 0; i < 6; i++) begin
            step1();
            chk("bp_hold_word", 64'(word), 64'h04030201);
            chk("bp_hold_valid", 64'(word_valid), 64'd1);
            chk("bp_hold_read", 64'(fifo_read), 64'd0);
        end
        word_ready = 1'b1;
        step1();
        chk("bp_accept_valid", 64'(word_valid), 64'd0);
        wait_valid("bp2");
        chk("bp_word2", 64'(word), 64'h08070605);
        step1();

        // Empty stall with two entries captured.
        push1(8'hA1); push1(8'hA2);
        step1(); step1();
        for (int i = 0; i < 3; i++) begin
            chk("stall_fill", 64'(fill_level), 64'd2);
            chk("stall_read", 64'(fifo_read), 64'd0);
            chk("stall_empty", 64'(fifo_empty), 64'd1);
            step1();
        end
        push1(8'hA3); push1(8'hA4);
        wait_valid("stall");
        chk("stall_word", 64'(word), 64'hA4A3A2A1);
        step1();

        // Flush of a partial word.
        push1(8'hDE); push1(8'hAD);
        step1(); step1();
        chk("flush_pre_fill", 64'(fill_level), 64'd2);
        flush = 1'b1;
        step1();
        flush = 1'b0;
        chk("flush_fill", 64'(fill_level), 64'd0);
        chk("flush_valid", 64'(word_valid), 64'd0);
        push1(8'h10); push1(8'h20); push1(8'h30); push1(8'h40);
        wait_valid("flush");
        chk("flush_word", 64'(word), 64'h40302010);
        step1();

        // Reset after three captures.
        push1(8'h5A); push1(8'h5B); push1(8'h5C);
        step1(); step1();
        chk("rstmid_pre_fill", 64'(fill_level), 64'd3);
        rst = 1'b0;
        step1();
        chk("rstmid_valid", 64'(word_valid), 64'd0);
        chk("rstmid_fill", 64'(fill_level), 64'd0);
        chk("rstmid_word", 64'(word), 64'd0);
        chk("rstmid_read", 64'(fifo_read), 64'd0);
        rst = 1'b1;
        push1(8'h61); push1(8'h62); push1(8'h63); push1(8'h64);
        wait_valid("rstmid");
        chk("rstmid_word2", 64'(word), 64'h64636261);
        step1();

        // Random push/ready traffic against the scoreboard, then drain.
        sb.delete();
        for (int cyc = 0; cyc < 1040; cyc++) begin
            if (cyc < 1000) begin
                push_en    = (fifo_q.size() < 8) && ($urandom_range(0, 99) < 60);
                push_val   = 8'($urandom);
                word_ready = ($urandom_range(0, 99) < 50);
            end else begin
                push_en    = 1'b0;
                word_ready = 1'b1;
            end
            if (push_en) sb.push_back(push_val);
            #1;
            chk("rand_read_empty", 64'(fifo_read && fifo_empty), 64'd0);
            if (word_valid && word_ready) begin
                if (sb.size() < BYTES) begin
                    chk("rand_sb_depth", 64'(sb.size()), 64'(BYTES));
                end else begin
                    exp_word = '0;
                    for (int k = 0; k < BYTES; k++) begin
                        exp_word[k*WIDTH +: WIDTH] = sb.pop_front();
                    end
                    chk("rand_word", 64'(word), 64'(exp_word));
                end
            end
            step1();
        end
        push_en = 1'b0;
        chk("rand_leftover", 64'(sb.size() < BYTES), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
